// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Purpose  : Front-panel time-setting controller. Debounces the mode/up/down
//            push-buttons, runs the RUN/SET_HOUR/SET_MIN/SET_SEC mode FSM,
//            drives the enable/load/preset inputs of the three time counters
//            and generates a per-field blink mask for the display stage.
// Ports    : clk_in_50M            - system clock
//            rst                   - asynchronous active-high reset
//            key_mode/up/down      - raw buttons, active-low, asynchronous
//            hour/min/sec_state    - current counter values (binary)
//            en_hour/min/sec       - counter enables (1 = count)
//            load_hour/min/sec     - counter loads (level, 1 = load data_*)
//            data_hour/min/sec     - preset values (binary)
//            blink_mask            - [2]=hour [1]=min [0]=sec, 1 = blank
//            mode                  - 0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES      = 1_000_000,
    parameter int BLINK_HALF_CYCLES    = 12_500_000,
    parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 5_000_000
) (
    input  logic       clk_in_50M,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [6:0] sec_state,
    input  logic [6:0] min_state,
    input  logic [6:0] hour_state,
    output logic       en_sec,
    output logic       en_min,
    output logic       en_hour,
    output logic       load_sec,
    output logic       load_min,
    output logic       load_hour,
    output logic [6:0] data_sec,
    output logic [6:0] data_min,
    output logic [6:0] data_hour,
    output logic [2:0] blink_mask,
    output logic [1:0] mode
);

    localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                              REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int c_RP_W  = $clog2(c_RP_MAX + 1);
    localparam int c_BL_W  = $clog2(BLINK_HALF_CYCLES + 1);

    // Key index: 2 = mode, 1 = up, 0 = down
    logic [2:0] w_key_raw;
    logic [2:0] w_press;
    logic [2:0] w_repeat;

    assign w_key_raw = {key_mode, key_up, key_down};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            logic              r_sync0;
            logic              r_sync1;
            logic              r_level;
            logic              r_level_prev;
            logic              r_press;
            logic [c_DB_W-1:0] r_db_cnt;
            logic              w_accept;

            // Synchronized level has disagreed for the full debounce window
            assign w_accept = (r_sync1 != r_level) &&
                              (r_db_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1));

            always_ff @(posedge clk_in_50M or posedge rst) begin
                if (rst) begin
                    r_sync0      <= 1'b1;
                    r_sync1      <= 1'b1;
                    r_level      <= 1'b1;
                    r_level_prev <= 1'b1;
                    r_press      <= 1'b0;
                    r_db_cnt     <= '0;
                end else begin
                    r_sync0      <= w_key_raw[gi];
                    r_sync1      <= r_sync0;
                    r_level_prev <= r_level;
                    r_press      <= r_level_prev & ~r_level;
                    if (r_sync1 == r_level) begin
                        r_db_cnt <= '0;
                    end else if (w_accept) begin
                        r_level  <= r_sync1;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_press;

            if (gi < 2) begin : g_repeat
                logic              r_rep;
                logic [c_RP_W-1:0] r_rep_cnt;
                logic              w_release;

                // A release accepted this cycle must suppress a repeat that
                // would otherwise land one cycle later.
                assign w_release = w_accept & r_sync1;

                // Down-counter reaching 1 marks the cycle before a repeat
                // pulse; it is then reloaded with the repeat period.
                always_ff @(posedge clk_in_50M or posedge rst) begin
                    if (rst) begin
                        r_rep     <= 1'b0;
                        r_rep_cnt <= '0;
                    end else if (r_level || w_release) begin
                        r_rep     <= 1'b0;
                        r_rep_cnt <= '0;
                    end else if (r_press) begin
                        r_rep     <= 1'b0;
                        r_rep_cnt <= c_RP_W'(REPEAT_DELAY_CYCLES - 1);
                    end else if (r_rep_cnt == c_RP_W'(1)) begin
                        r_rep     <= 1'b1;
                        r_rep_cnt <= c_RP_W'(REPEAT_PERIOD_CYCLES);
                    end else begin
                        r_rep <= 1'b0;
                        if (r_rep_cnt != '0) begin
                            r_rep_cnt <= r_rep_cnt - 1'b1;
                        end
                    end
                end

                assign w_repeat[gi] = r_rep;
            end else begin : g_no_repeat
                assign w_repeat[gi] = 1'b0;
            end
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_en;
    logic              r_load;
    logic [6:0]        r_edit_h;
    logic [6:0]        r_edit_m;
    logic [6:0]        r_edit_s;
    logic [c_BL_W-1:0] r_blink_cnt;
    logic              r_blink_phase;
    logic [2:0]        r_blink_mask;

    logic w_mode_ev;
    logic w_up;
    logic w_dn;
    logic w_step;

    // Mode wins over a coincident step; up together with down cancels out.
    assign w_mode_ev = w_press[2];
    assign w_up      = w_press[1] | w_repeat[1];
    assign w_dn      = w_press[0] | w_repeat[0];
    assign w_step    = (w_up ^ w_dn) && !w_mode_ev && (r_state != ST_RUN);

    function automatic logic [2:0] field_sel(input state_t s);
        case (s)
            ST_SET_HOUR: field_sel = 3'b100;
            ST_SET_MIN:  field_sel = 3'b010;
            ST_SET_SEC:  field_sel = 3'b001;
            default:     field_sel = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk_in_50M or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_en          <= 1'b1;
            r_load        <= 1'b0;
            r_edit_h      <= 7'd0;
            r_edit_m      <= 7'd0;
            r_edit_s      <= 7'd0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blink_mask  <= 3'b000;
        end else if (w_mode_ev) begin
            // Every state change restarts the blink with the field visible
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blink_mask  <= 3'b000;
            case (r_state)
                ST_RUN: begin
                    r_state  <= ST_SET_HOUR;
                    r_en     <= 1'b0;
                    r_load   <= 1'b1;
                    r_edit_h <= (hour_state < 7'd24) ? hour_state : 7'd0;
                    r_edit_m <= (min_state  < 7'd60) ? min_state  : 7'd0;
                    r_edit_s <= (sec_state  < 7'd60) ? sec_state  : 7'd0;
                end
                ST_SET_HOUR: r_state <= ST_SET_MIN;
                ST_SET_MIN:  r_state <= ST_SET_SEC;
                default: begin
                    r_state <= ST_RUN;
                    r_en    <= 1'b1;
                    r_load  <= 1'b0;
                end
            endcase
        end else if (w_step) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blink_mask  <= 3'b000;
            case (r_state)
                ST_SET_HOUR: begin
                    if (w_up) r_edit_h <= (r_edit_h == 7'd23) ? 7'd0  : r_edit_h + 7'd1;
                    else      r_edit_h <= (r_edit_h == 7'd0)  ? 7'd23 : r_edit_h - 7'd1;
                end
                ST_SET_MIN: begin
                    if (w_up) r_edit_m <= (r_edit_m == 7'd59) ? 7'd0  : r_edit_m + 7'd1;
                    else      r_edit_m <= (r_edit_m == 7'd0)  ? 7'd59 : r_edit_m - 7'd1;
                end
                default: begin
                    if (w_up) r_edit_s <= (r_edit_s == 7'd59) ? 7'd0  : r_edit_s + 7'd1;
                    else      r_edit_s <= (r_edit_s == 7'd0)  ? 7'd59 : r_edit_s - 7'd1;
                end
            endcase
        end else if (r_blink_cnt == c_BL_W'(BLINK_HALF_CYCLES - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
            // Mask mirrors the phase that becomes current after this edge
            r_blink_mask  <= field_sel(r_state) & {3{~r_blink_phase}};
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign en_hour    = r_en;
    assign en_min     = r_en;
    assign en_sec     = r_en;
    assign load_hour  = r_load;
    assign load_min   = r_load;
    assign load_sec   = r_load;
    assign data_hour  = r_edit_h;
    assign data_min   = r_edit_m;
    assign data_sec   = r_edit_s;
    assign blink_mask = r_blink_mask;
    assign mode       = r_state;

endmodule
`default_nettype wire
